// File: rtl/sw_led_bank_if.sv
// Switch/LED bus between the board-facing logic and the sw_led_bank block.
interface sw_led_bank_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw;
  logic [1:0]       mode;
  logic             tick;
  logic [WIDTH-1:0] led;
  logic [WIDTH-1:0] sw_db;
  logic             changed;

  modport master (
    output sw, mode, tick,
    input  led, sw_db, changed
  );

  modport slave (
    input  sw, mode, tick,
    output led, sw_db, changed
  );
endinterface

// File: rtl/sw_led_bank.sv
// Switch synchroniser/debouncer driving a registered LED bank with four
// display modes: passthrough, toggle-latch, chase and invert.
module sw_led_bank #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input logic          clk,
  input logic          rst,
  sw_led_bank_if.slave bus
);

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_CHASE  = 2'b10;
  localparam logic [1:0] MODE_INVERT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CHASE_INIT = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            db_q, db_d;
  logic                        changed_q, changed_d;
  logic [WIDTH-1:0]            toggle_q, toggle_d;
  logic [WIDTH-1:0]            chase_q, chase_d;
  logic [WIDTH-1:0]            led_q, led_d;
  logic [WIDTH-1:0]            upd;

  // Two-flop synchroniser for the raw, asynchronous switch pins
  always_comb begin
    sync1_d = bus.sw;
    sync2_d = sync1_q;
  end

  // Per-bit debounce: accept a new level only after it disagrees with the
  // current debounced value for DEBOUNCE_CYCLES consecutive edges
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    upd   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
        upd[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    changed_d = |upd;
  end

  // Toggle latch flips on debounced rising edges, only while in toggle mode
  always_comb begin
    toggle_d = toggle_q;
    if (bus.mode == MODE_TOGGLE) begin
      toggle_d = toggle_q ^ (upd & sync2_q);
    end
  end

  // One-hot chase rotates on tick in chase mode; sw_db[0] picks direction
  always_comb begin
    chase_d = chase_q;
    if ((bus.mode == MODE_CHASE) && bus.tick) begin
      if (db_q[0]) begin
        chase_d = {chase_q[0], chase_q[WIDTH-1:1]};
      end else begin
        chase_d = {chase_q[WIDTH-2:0], chase_q[WIDTH-1]};
      end
    end
  end

  // LED source select from the currently registered state
  always_comb begin
    led_d = db_q;
    case (bus.mode)
      MODE_PASS:   led_d = db_q;
      MODE_TOGGLE: led_d = toggle_q;
      MODE_CHASE:  led_d = chase_q;
      MODE_INVERT: led_d = ~db_q;
      default:     led_d = db_q;
    endcase
  end

  // All state registers; reset clears everything except the chase seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      db_q      <= '0;
      changed_q <= 1'b0;
      toggle_q  <= '0;
      chase_q   <= CHASE_INIT;
      led_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      changed_q <= changed_d;
      toggle_q  <= toggle_d;
      chase_q   <= chase_d;
      led_q     <= led_d;
    end
  end

  assign bus.led     = led_q;
  assign bus.sw_db   = db_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_sw_led_bank.sv
// Bench for sw_led_bank (WIDTH=8, DEBOUNCE_CYCLES=4): directed scenarios
// with fixed expectations plus randomized traffic against a reference model.
module tb_sw_led_bank;

  localparam int W  = 8;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sw_led_bank_if #(.WIDTH(W)) bus ();

  sw_led_bank #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: synchroniser as a two-sample delay, debounce as a run
  // length of disagreement, chase as a bit position modulo W.
  logic [W-1:0] m_s1, m_s2, m_db, m_lat, m_led;
  logic         m_chg;
  int           m_run [W];
  int           m_pos;

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_lat = '0; m_led = '0; m_chg = 1'b0;
    m_pos = 0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic m_edge(input logic [W-1:0] s, input logic [1:0] md, input logic t);
    logic [W-1:0] n_db;
    case (md)
      2'd0: m_led = m_db;
      2'd1: m_led = m_lat;
      2'd2: m_led = W'(1) << m_pos;
      default: m_led = ~m_db;
    endcase
    n_db = m_db;
    for (int i = 0; i < W; i++) begin
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          n_db[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (md == 2'd1) m_lat = m_lat ^ (n_db & ~m_db);
    if (md == 2'd2 && t) m_pos = m_db[0] ? (m_pos + W - 1) % W : (m_pos + 1) % W;
    m_chg = (n_db != m_db);
    m_db  = n_db;
    m_s2  = m_s1;
    m_s1  = s;
  endtask

  // Apply inputs at the falling edge, clock once, settle at the next falling edge
  task automatic cycle(input logic [W-1:0] s, input logic [1:0] md, input logic t);
    bus.sw = s; bus.mode = md; bus.tick = t;
    @(posedge clk);
    m_edge(s, md, t);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sw = '0; bus.mode = 2'd0; bus.tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sw = '0; bus.mode = 2'd0; bus.tick = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.led, bus.sw_db, bus.changed} !== 17'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: led=%h sw_db=%h changed=%b, want all 0", bus.led, bus.sw_db, bus.changed);
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    cycle(8'h00, 2'd2, 1'b0);
    vec_cnt++;
    if (bus.led !== 8'h01) begin
      err_cnt++;
      $display("FAIL reset_chase_seed: led=%h want 01", bus.led);
    end
  endtask

  task automatic test_passthrough();
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      logic [W-1:0] x_db, x_led;
      logic         x_chg;
      cycle(8'hA5, 2'd0, 1'b0);
      x_db  = (e >= 6) ? 8'hA5 : 8'h00;
      x_led = (e >= 7) ? 8'hA5 : 8'h00;
      x_chg = (e == 6);
      vec_cnt++;
      if (bus.sw_db !== x_db || bus.led !== x_led || bus.changed !== x_chg) begin
        err_cnt++;
        $display("FAIL passthrough edge %0d: led=%h sw_db=%h changed=%b, want led=%h sw_db=%h changed=%b",
                 e, bus.led, bus.sw_db, bus.changed, x_led, x_db, x_chg);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      cycle((e <= 3) ? 8'h01 : 8'h00, 2'd0, 1'b0);
      vec_cnt++;
      if ({bus.led, bus.sw_db, bus.changed} !== 17'd0) begin
        err_cnt++;
        $display("FAIL bounce_reject edge %0d: led=%h sw_db=%h changed=%b, want 0", e, bus.led, bus.sw_db, bus.changed);
      end
    end
    for (int e = 1; e <= 6; e++) begin
      logic [W-1:0] x_db;
      cycle(8'h01, 2'd0, 1'b0);
      x_db = (e >= 6) ? 8'h01 : 8'h00;
      vec_cnt++;
      if (bus.sw_db !== x_db) begin
        err_cnt++;
        $display("FAIL bounce_accept edge %0d: sw_db=%h want %h", e, bus.sw_db, x_db);
      end
    end
  endtask

  task automatic test_toggle();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      logic [W-1:0] x_led;
      repeat (8) cycle((p % 2 == 0) ? 8'h04 : 8'h00, 2'd1, 1'b0);
      x_led = (p < 2) ? 8'h04 : 8'h00;
      vec_cnt++;
      if (bus.led !== x_led) begin
        err_cnt++;
        $display("FAIL toggle phase %0d: led=%h want %h", p, bus.led, x_led);
      end
    end
  endtask

  task automatic test_chase();
    do_reset();
    cycle(8'h00, 2'd2, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      logic [W-1:0] x_led;
      cycle(8'h00, 2'd2, 1'b1);
      cycle(8'h00, 2'd2, 1'b0);
      cycle(8'h00, 2'd2, 1'b0);
      x_led = 8'h01 << (k % 8);
      vec_cnt++;
      if (bus.led !== x_led) begin
        err_cnt++;
        $display("FAIL chase_left step %0d: led=%h want %h", k, bus.led, x_led);
      end
    end
    repeat (7) cycle(8'h01, 2'd2, 1'b0);
    cycle(8'h01, 2'd2, 1'b1);
    cycle(8'h01, 2'd2, 1'b0);
    vec_cnt++;
    if (bus.led !== 8'h80) begin
      err_cnt++;
      $display("FAIL chase_right_wrap: led=%h want 80", bus.led);
    end
    repeat (3) cycle(8'h01, 2'd0, 1'b1);
    cycle(8'h01, 2'd2, 1'b0);
    vec_cnt++;
    if (bus.led !== 8'h80) begin
      err_cnt++;
      $display("FAIL chase_tick_ignored: led=%h want 80", bus.led);
    end
  endtask

  task automatic test_invert_mode();
    do_reset();
    repeat (8) cycle(8'h03, 2'd1, 1'b0);
    repeat (8) cycle(8'h0F, 2'd3, 1'b0);
    vec_cnt++;
    if (bus.led !== 8'hF0) begin
      err_cnt++;
      $display("FAIL invert: led=%h want f0", bus.led);
    end
    cycle(8'h0F, 2'd1, 1'b0);
    vec_cnt++;
    if (bus.led !== 8'h03) begin
      err_cnt++;
      $display("FAIL mode_switch_latch: led=%h want 03", bus.led);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (8) cycle(8'h0F, 2'd0, 1'b0);
    cycle(8'h0F, 2'd2, 1'b1);
    cycle(8'h0F, 2'd2, 1'b1);
    repeat (3) cycle(8'hFF, 2'd0, 1'b0);
    vec_cnt++;
    if (bus.led !== 8'h0F) begin
      err_cnt++;
      $display("FAIL pre_reset_led: led=%h want 0f", bus.led);
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({bus.led, bus.sw_db, bus.changed} !== 17'd0) begin
      err_cnt++;
      $display("FAIL async_reset: led=%h sw_db=%h changed=%b, want all 0", bus.led, bus.sw_db, bus.changed);
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int e = 1; e <= 6; e++) begin
      logic [W-1:0] x_db;
      cycle(8'hFF, 2'd0, 1'b0);
      x_db = (e >= 6) ? 8'hFF : 8'h00;
      vec_cnt++;
      if (bus.sw_db !== x_db) begin
        err_cnt++;
        $display("FAIL post_reset_debounce edge %0d: sw_db=%h want %h", e, bus.sw_db, x_db);
      end
    end
    cycle(8'hFF, 2'd2, 1'b0);
    vec_cnt++;
    if (bus.led !== 8'h01) begin
      err_cnt++;
      $display("FAIL post_reset_chase: led=%h want 01", bus.led);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] s;
    logic [1:0]   md;
    do_reset();
    s  = '0;
    md = 2'd0;
    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] drive;
      if ($urandom_range(0, 9) == 0) s = W'($urandom);
      if ($urandom_range(0, 19) == 0) md = 2'($urandom);
      drive = s;
      if ($urandom_range(0, 7) == 0) drive = s ^ (W'(1) << $urandom_range(0, W - 1));
      cycle(drive, md, ($urandom_range(0, 2) == 0));
      vec_cnt++;
      if (bus.led !== m_led || bus.sw_db !== m_db || bus.changed !== m_chg) begin
        err_cnt++;
        $display("FAIL random cycle %0d: led=%h sw_db=%h changed=%b, want led=%h sw_db=%h changed=%b",
                 n, bus.led, bus.sw_db, bus.changed, m_led, m_db, m_chg);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_passthrough();
    test_bounce();
    test_toggle();
    test_chase();
    test_invert_mode();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sw_led_bank.md
Name: sw_led_bank

Overview:
- Parametrised successor to the plain switch-to-LED passthrough.
- Takes WIDTH raw board switches and synchronises and debounces each one.
- Drives WIDTH registered LEDs in one of four selectable display modes: passthrough, toggle-latch, chase and invert.
- Sits directly between the board switch pins and the LED pins of the top-level lab design.

Parameters:
- WIDTH, 8, number of switch/LED channels (>=2).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a switch change is accepted (>=2).
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, width of each per-channel debounce counter (derived; do not override).

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw  input  WIDTH  raw switch inputs, asynchronous to clk.
- mode  input  2  display mode: 00 passthrough, 01 toggle, 10 chase, 11 invert.
- tick  input  1  single-cycle advance strobe for chase mode.
- led  output  WIDTH  registered LED drive.
- sw_db  output  WIDTH  debounced switch state.
- changed  output  1  one-cycle pulse when any sw_db bit changes.

Behaviour:
- Reset: asynchronous assertion forces the following immediately, regardless of clk.
  - Sync flops, debounce counters, sw_db, toggle latch, led and changed all go to 0.
  - Chase register goes to 1 (bit 0 set).
- Synchroniser: two flops per bit; sync2 is the synchronised value.
- Debounce, per bit i, evaluated at every edge:
  - If sync2[i] == sw_db[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: sw_db[i] <= sync2[i] and counter <= 0.
  - Else: counter <= counter+1.
  - Any return to the old value before the count completes clears the counter (glitch rejected).
- changed: registered at the same edge as the sw_db update; high for exactly one cycle if any bit updated that edge. Simultaneous multi-bit updates still give a single pulse.
- Latency: a sw change held stable before edge 1 reaches sw_db at edge 2+DEBOUNCE_CYCLES and reaches led at edge 3+DEBOUNCE_CYCLES.
- Toggle latch:
  - Latch bit i inverts at the same edge sw_db[i] goes 0->1, only while mode==01.
  - Falling edges are ignored.
  - The latch holds its value in all other modes, including across mode changes.
- Chase register:
  - Advances only when mode==10 and tick==1; holds otherwise.
  - Rotates left by one if sw_db[0]==0, right by one if sw_db[0]==1.
  - MSB wraps to LSB (or LSB to MSB) and always stays one-hot.
- led, registered each edge from the current mode:
  - 00: sw_db.
  - 01: toggle latch.
  - 10: chase register.
  - 11: ~sw_db.
  - Mode change takes effect on led at the next edge; no other state is disturbed.
- Reset mid-debounce or mid-chase aborts all progress; after deassertion the block behaves exactly as from power-up.
- tick while not in mode 10 is ignored.

Test Plan (WIDTH=8, DEBOUNCE_CYCLES=4):
- Passthrough: mode=00, sw 0x00->0xA5 held -> sw_db=0xA5 at edge 6, changed high for that one cycle only, led=0xA5 at edge 7.
- Bounce: sw[0]=1 for 3 cycles then 0 -> sw_db, led and changed stay 0. Then sw[0]=1 held -> sw_db=0x01 after 6 edges.
- Toggle: mode=01, press/release sw[2] (each phase held 8 cycles) twice -> led 0x04 after first press, 0x00 after second; release phases leave led unchanged.
- Chase: mode=10, sw_db[0]=0, tick every 3 cycles -> led 0x01,0x02,...,0x80,0x01. Then set sw[0]=1 -> next tick gives 0x80 from 0x01. tick in mode 00 does not move the register.
- Invert and mode switch: sw=0x0F debounced, mode=11 -> led=0xF0. Switch to mode 01 -> led shows the retained latch value on the next edge.
- Async reset: assert rst mid-count with sw=0xFF, between clk edges -> led, sw_db and changed are 0 immediately. After release with sw held, sw_db=0xFF after 6 edges and chase restarts at 0x01.
